seq_div8: RTL
=============

# seq_div8

Sequential unsigned restoring divider for the arithmetic library. It is the inverse-direction companion of the 8-bit parallel adder/subtractor: it consumes repeated shift-and-subtract steps instead of producing a single sum or difference. It takes a dividend and divisor on a start pulse, iterates one quotient bit per clock, and presents quotient and remainder with a one-cycle `done` pulse. It sits behind any datapath controller that needs division without a combinational array divider.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width. Legal range is 2..16.
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `start`, input, 1 bit: request. Sampled only in IDLE.
- `dividend`, input, `WIDTH` bits: unsigned dividend. Captured on an accepted start.
- `divisor`, input, `WIDTH` bits: unsigned divisor. Captured on an accepted start.
- `busy`, output, 1 bit: high whenever state is not IDLE.
- `done`, output, 1 bit: one-cycle pulse, high only in state FIN.
- `quotient`, output, `WIDTH` bits: result register. Holds its value until the next FIN.
- `remainder`, output, `WIDTH` bits: result register. Holds its value until the next FIN.
- `div_by_zero`, output, 1 bit: flag for the last completed operation. Updated on entry to FIN.

## Operation
- States are IDLE, CALC and FIN. Encoding is free.
- IDLE with `start`=1:
  - Capture the operands into working registers.
  - Clear the iteration counter.
  - If the captured divisor is 0, go to FIN directly. Otherwise go to CALC.
- IDLE with `start`=0: stay in IDLE.
- CALC performs one iteration per clock, `WIDTH` iterations total.
  - The partial remainder R is `WIDTH`+1 bits wide and starts at 0. Working quotient Q starts equal to the dividend.
  - Shift step: R ← {R[WIDTH-1:0], Q[WIDTH-1]}, and Q ← Q << 1.
  - Trial step: T = R − {0, divisor}, computed `WIDTH`+1 bits wide.
  - If T[WIDTH] = 1 (borrow): R is unchanged and Q[0] = 0.
  - Otherwise: R = T and Q[0] = 1.
  - After the `WIDTH`-th iteration, go to FIN. Load `quotient` ← Q, `remainder` ← R[WIDTH-1:0], and `div_by_zero` ← 0.
- Divide by zero: on entering FIN, load `quotient` ← all ones, `remainder` ← dividend, and `div_by_zero` ← 1.
- FIN asserts `done` for exactly one cycle, then returns to IDLE unconditionally.
- `start` is ignored in CALC and FIN. No queuing and no restart occur.
- Operand inputs may change freely after an accepted start; only the captured copies are used.
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter 0.
- Reset mid-operation: the operation is aborted immediately. No `done` is produced and the outputs take their reset values.

## Timing
- Let E0 be the rising edge that samples `start`=1 in IDLE.
- Normal divide:
  - Iterations occur at edges E1..E`WIDTH`.
  - Results load at E`WIDTH`.
  - `done`=1 between E`WIDTH` and E`WIDTH`+1, with the results valid in that same cycle.
  - `busy`=1 from E0 through E`WIDTH`+1.
  - Total latency from start to done is `WIDTH` cycles, which is 8 by default.
- Divide by zero:
  - FIN is entered at E0.
  - `done`=1 between E0 and E1, and `busy`=1 for that single cycle.
- Back-to-back operation: a `start` held high through FIN is accepted at the edge that returns to IDLE+1. The earliest re-accept is the first edge at which the state is IDLE. Throughput is one operation per `WIDTH`+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- 200 / 7 → `done` 8 cycles after start, `quotient`=28, `remainder`=4, `div_by_zero`=0.
- 255 / 1 → `quotient`=255, `remainder`=0. Then 5 / 9 → `quotient`=0, `remainder`=5. Then 255 / 255 → `quotient`=1, `remainder`=0.
- 77 / 0 → `done` 1 cycle after start, `quotient`=255, `remainder`=77, `div_by_zero`=1. A following 10 / 3 clears the flag and gives `quotient`=3, `remainder`=1.
- Start 100 / 10, then pulse `start` with 9 / 2 during CALC and again during FIN → both pulses ignored. Exactly one `done`, with `quotient`=10, `remainder`=0.
- Assert `rst_n`=0 four cycles into CALC → `busy`, `done`, `quotient`, `remainder` and `div_by_zero` go to 0 asynchronously, and no `done` follows. After release, 50 / 6 → `quotient`=8, `remainder`=2.
- Random sweep of all legal dividend/divisor pairs (exhaustive for `WIDTH`=8) against a reference model. Check that `done` is a single-cycle pulse and that `busy` is never high in IDLE.

Source files
------------

// File: rtl/seq_div8.sv
// rtl/seq_div8.sv - sequential unsigned restoring divider, one quotient bit per clock
module seq_div8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // The restored partial remainder is always below the divisor, so WIDTH bits
  // suffice between iterations; only the shifted trial value needs WIDTH+1.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    r_sh   = {r_q, q_q[WIDTH-1]};
    trial  = r_sh - {1'b0, dvs_q};
    r_next = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvs_d = divisor;
          q_d   = dividend;
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = S_FIN;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_FIN;
          quo_d   = q_next;
          rem_d   = r_next;
          dbz_d   = 1'b0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
